// File: rtl/rcc_test_mode_pkg.sv
// Shared definitions for the test-mode entry/exit sequencer.
package rcc_test_mode_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [3:0] {
        ST_FUNC     = 4'd0,
        ST_QUIESCE  = 4'd1,
        ST_RST_ON   = 4'd2,
        ST_SCAN_ON  = 4'd3,
        ST_TEST_RUN = 4'd4,
        ST_RST_EXIT = 4'd5,
        ST_SCAN_OFF = 4'd6,
        ST_TM_OFF   = 4'd7,
        ST_RESUME   = 4'd8
    } state_e;

    // Registered output bundle, one bit per sequencer output
    typedef struct packed {
        logic clk_en;
        logic testmode;
        logic scan_mode;
        logic test_rst_n;
        logic test_ack;
        logic busy;
    } tm_out_t;

    localparam tm_out_t OUT_RESET = '{
        clk_en:     1'b1,
        testmode:   1'b0,
        scan_mode:  1'b0,
        test_rst_n: 1'b1,
        test_ack:   1'b0,
        busy:       1'b0
    };

    // Per-state output table: clk_en, testmode, scan_mode, test_rst_n, test_ack, busy
    function automatic tm_out_t state_out(input state_e s);
        tm_out_t o;
        o = OUT_RESET;
        case (s)
            ST_FUNC:     o = 6'b100100;
            ST_QUIESCE:  o = 6'b000101;
            ST_RST_ON:   o = 6'b010001;
            ST_SCAN_ON:  o = 6'b011001;
            ST_TEST_RUN: o = 6'b011110;
            ST_RST_EXIT: o = 6'b011001;
            ST_SCAN_OFF: o = 6'b010001;
            ST_TM_OFF:   o = 6'b000101;
            ST_RESUME:   o = 6'b000101;
            default:     o = OUT_RESET;
        endcase
        return o;
    endfunction

    // States whose dwell time is set by the settle counter
    function automatic logic is_timed(input state_e s);
        logic t;
        t = 1'b0;
        case (s)
            ST_QUIESCE, ST_RST_ON, ST_SCAN_ON,
            ST_RST_EXIT, ST_SCAN_OFF, ST_TM_OFF, ST_RESUME: t = 1'b1;
            default:                                        t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rcc_settle_cnt.sv
// Loadable settle down-counter; cnt_done flags the last cycle of a timed state.
module rcc_settle_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             cnt_done
);

    logic [CNT_W-1:0] cnt_q;

    // Load max(load_val,1) on entry, then count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (load_val == '0) ? CNT_W'(1) : load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cnt_done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rcc_test_mode_seq.sv
// Sequences clock quiesce, reset-mux and clock-mux switching into and out of test mode.
module rcc_test_mode_seq
    import rcc_test_mode_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             test_req,
    input  logic [CNT_W-1:0] settle_cycles,
    output logic             clk_en,
    output logic             testmode,
    output logic             scan_mode,
    output logic             test_rst_n,
    output logic             test_ack,
    output logic             busy
);

    state_e  state_q;
    state_e  state_nxt;
    tm_out_t out_q;
    logic    cnt_load;
    logic    cnt_done;

    rcc_settle_cnt #(
        .CNT_W (CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (settle_cycles),
        .cnt_done (cnt_done)
    );

    // Next-state logic including aborts out of the entry path
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_FUNC: begin
                if (test_req) state_nxt = ST_QUIESCE;
            end
            ST_QUIESCE: begin
                if (!test_req)     state_nxt = ST_RESUME;
                else if (cnt_done) state_nxt = ST_RST_ON;
            end
            ST_RST_ON: begin
                if (!test_req)     state_nxt = ST_TM_OFF;
                else if (cnt_done) state_nxt = ST_SCAN_ON;
            end
            ST_SCAN_ON: begin
                if (!test_req)     state_nxt = ST_SCAN_OFF;
                else if (cnt_done) state_nxt = ST_TEST_RUN;
            end
            ST_TEST_RUN: begin
                if (!test_req) state_nxt = ST_RST_EXIT;
            end
            ST_RST_EXIT: begin
                if (cnt_done) state_nxt = ST_SCAN_OFF;
            end
            ST_SCAN_OFF: begin
                if (cnt_done) state_nxt = ST_TM_OFF;
            end
            ST_TM_OFF: begin
                if (cnt_done) state_nxt = ST_RESUME;
            end
            ST_RESUME: begin
                if (cnt_done) state_nxt = ST_FUNC;
            end
            default: state_nxt = ST_FUNC;
        endcase
    end

    // Reload the settle counter whenever a timed state is entered
    assign cnt_load = (state_nxt != state_q) && is_timed(state_nxt);

    // State and output registers; outputs follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FUNC;
            out_q   <= OUT_RESET;
        end else begin
            state_q <= state_nxt;
            out_q   <= state_out(state_nxt);
        end
    end

    assign clk_en     = out_q.clk_en;
    assign testmode   = out_q.testmode;
    assign scan_mode  = out_q.scan_mode;
    assign test_rst_n = out_q.test_rst_n;
    assign test_ack   = out_q.test_ack;
    assign busy       = out_q.busy;

endmodule

// File: doc/rcc_test_mode_seq.md
RCC_TEST_MODE_SEQ -- requirements
Module: rcc_test_mode_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the settle counter and of settle_cycles.
REQ-002 SHALL have port clk  input  1  single block clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port test_req  input  1  level request to enter test mode; low requests exit.
REQ-005 SHALL have port settle_cycles  input  CNT_W  length N of each timed state in cycles.
REQ-006 SHALL have port clk_en  output  1  functional clock enable; 0 quiesces clocks ahead of the clock-mux switch.
REQ-007 SHALL have port testmode  output  1  drives the reset-mux select.
REQ-008 SHALL have port scan_mode  output  1  drives the clock-mux select.
REQ-009 SHALL have port test_rst_n  output  1  test reset to the reset muxes, active low.
REQ-010 SHALL have port test_ack  output  1  high only while the sequencer is in TEST_RUN.
REQ-011 SHALL have port busy  output  1  high in every state except FUNC and TEST_RUN.

Function
REQ-012 SHALL implement states FUNC, QUIESCE, RST_ON, SCAN_ON, TEST_RUN, RST_EXIT, SCAN_OFF, TM_OFF and RESUME.
REQ-013 SHALL drive all outputs from flops, so each output changes on the same edge that enters the new state.
REQ-014 SHALL use these output values per state (clk_en/testmode/scan_mode/test_rst_n): FUNC 1/0/0/1; QUIESCE 0/0/0/1; RST_ON 0/1/0/0; SCAN_ON 0/1/1/0; TEST_RUN 0/1/1/1; RST_EXIT 0/1/1/0; SCAN_OFF 0/1/0/0; TM_OFF 0/0/0/1; RESUME 0/0/0/1.
REQ-015 SHALL keep every timed state (QUIESCE, RST_ON, SCAN_ON, RST_EXIT, SCAN_OFF, TM_OFF, RESUME) for exactly N = max(settle_cycles, 1) cycles.
REQ-016 SHALL sample settle_cycles on each timed-state entry; changes within a state SHALL have no effect on that state.
REQ-017 SHALL implement N with a CNT_W-bit down-counter that is loaded on entry and advances the state when the count equals 1; the counter SHALL never wrap.
REQ-018 SHALL move FUNC->QUIESCE on the edge at which test_req is sampled high.
REQ-019 SHALL follow the entry path QUIESCE->RST_ON->SCAN_ON->TEST_RUN, so test_ack rises 3N+1 cycles after test_req is sampled.
REQ-020 SHALL move TEST_RUN->RST_EXIT on the edge at which test_req is sampled low.
REQ-021 SHALL follow the exit path RST_EXIT->SCAN_OFF->TM_OFF->RESUME->FUNC, so clk_en returns to 1 4N+1 cycles after test_req is sampled low.
REQ-022 SHALL abort immediately, with a counter reload, when test_req is sampled low during an entry state: QUIESCE->RESUME, RST_ON->TM_OFF, SCAN_ON->SCAN_OFF.
REQ-023 SHALL ignore test_req high during any exit state; re-entry SHALL be evaluated only in FUNC.
REQ-024 SHALL never change scan_mode while clk_en=1, and never change scan_mode and testmode on the same edge.
REQ-025 SHALL assert test_rst_n low for at least N cycles around every scan_mode edge.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force state FUNC with clk_en=1, testmode=0, scan_mode=0, test_rst_n=1, test_ack=0, busy=0 and counter=0.
REQ-027 SHALL release reset synchronously to clk; the first transition is evaluated on the first edge after deassertion.
REQ-028 SHALL treat reset asserted mid-sequence as returning to FUNC values at once, with no exit sequencing.

Structure
REQ-029 SHALL place the state encoding (4-bit enum), the CNT_W default and the per-state output table in shared package rcc_test_mode_pkg.
REQ-030 SHALL implement the loadable down-counter as sub-module rcc_settle_cnt (ports: load, load_val, cnt_done).
REQ-031 SHALL keep the FSM, output registers and abort logic in rcc_test_mode_seq; there SHALL be no other hierarchy.

Verification
REQ-032 Entry/exit, N=4: test_req 0->1 -> clk_en=0 at +1, testmode=1 and test_rst_n=0 at +5, scan_mode=1 at +9, test_ack=1 and test_rst_n=1 at +13; test_req 1->0 -> clk_en=1 at +17.
REQ-033 settle_cycles=0: full entry -> test_ack at +4 (N=1); exit -> clk_en=1 at +5.
REQ-034 Abort, N=4: test_req drops 2 cycles into SCAN_ON -> SCAN_OFF next edge, scan_mode=0, test_ack never asserts, busy=1 until FUNC.
REQ-035 Re-request during TM_OFF -> ignored until FUNC; re-entry starts the cycle after FUNC is reached.
REQ-036 rst_n pulsed low during RST_ON -> all outputs take reset values asynchronously; FUNC after release.
REQ-037 Bench SHALL assert REQ-024 and REQ-025 continuously under random test_req toggling and random settle_cycles values 0..255.
